// File: rtl/xix_prefix_sequencer.sv
// DD/FD prefix sequencer: captures opcode and displacement bytes, tracks the
// IX/IY prefix flags and the DD CB / FD CB sub-sequence, runs the XPT phase
// counter and drives the decoder enables.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_FETCH   | waiting for an M1 byte; DD/FD set prefix flags, others decode
// ST_EXEC    | executing a plain or DD/FD-prefixed opcode
// ST_X4_DISP | DD CB / FD CB: waiting for the displacement byte
// ST_X4_OP   | DD CB / FD CB: waiting for the final opcode byte
// ST_X4_EXEC | executing a DD CB / FD CB opcode
module xix_prefix_sequencer #(
    parameter int XPT_MAX = 31
) (
    input  logic       CLK,
    input  logic       notReset,
    input  logic [7:0] Dt_in,
    input  logic       fetch_valid,
    input  logic       step,
    input  logic       P2_Set_CM1,
    input  logic       PR_Reset_XPT,
    input  logic       P2_Reset_XIX,
    input  logic       P2_Reset_XIY,
    input  logic       P2_Set_XIX4_0,
    input  logic       P2_Set_XIY4_0,
    output logic [7:0] Source,
    output logic [7:0] notSource,
    output logic [4:0] XPT,
    output logic [4:0] notXPT,
    output logic       is_Y,
    output logic [7:0] Disp,
    output logic       CM1,
    output logic       XIX_enable,
    output logic       Main_enable,
    output logic       XIX4_enable
);

    localparam logic [4:0] XPT_SAT   = XPT_MAX[4:0];
    localparam logic [7:0] PREFIX_DD = 8'hDD;
    localparam logic [7:0] PREFIX_FD = 8'hFD;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_EXEC    = 3'd1,
        ST_X4_DISP = 3'd2,
        ST_X4_OP   = 3'd3,
        ST_X4_EXEC = 3'd4
    } state_t;

    state_t     state, nxt_state;
    logic       xix, xiy, nxt_xix, nxt_xiy;
    logic [7:0] nxt_source, nxt_disp;
    logic [4:0] nxt_xpt;

    assign is_Y = xiy;

    // Next-state, flag, byte-latch and phase-counter computation.
    always_comb begin
        nxt_state  = state;
        nxt_xix    = xix;
        nxt_xiy    = xiy;
        nxt_source = Source;
        nxt_disp   = Disp;

        if (PR_Reset_XPT) begin
            nxt_xpt = 5'd0;
        end else if (step && (XPT < XPT_SAT)) begin
            nxt_xpt = XPT + 5'd1;
        end else begin
            nxt_xpt = XPT;
        end

        case (state)
            ST_FETCH: begin
                if (fetch_valid) begin
                    if (Dt_in == PREFIX_DD) begin
                        nxt_xix = 1'b1;
                        nxt_xiy = 1'b0;
                    end else if (Dt_in == PREFIX_FD) begin
                        nxt_xix = 1'b0;
                        nxt_xiy = 1'b1;
                    end else begin
                        nxt_source = Dt_in;
                        nxt_xpt    = 5'd0;
                        nxt_state  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                // End-of-instruction outranks entry into the CB sub-sequence.
                if (P2_Set_CM1) begin
                    nxt_state = ST_FETCH;
                end else if (P2_Set_XIX4_0) begin
                    nxt_state = ST_X4_DISP;
                    nxt_xpt   = 5'd0;
                    nxt_xix   = 1'b1;
                    nxt_xiy   = 1'b0;
                end else if (P2_Set_XIY4_0) begin
                    nxt_state = ST_X4_DISP;
                    nxt_xpt   = 5'd0;
                    nxt_xix   = 1'b0;
                    nxt_xiy   = 1'b1;
                end
            end
            ST_X4_DISP: begin
                if (fetch_valid) begin
                    nxt_disp  = Dt_in;
                    nxt_state = ST_X4_OP;
                end
            end
            ST_X4_OP: begin
                if (fetch_valid) begin
                    nxt_source = Dt_in;
                    nxt_xpt    = 5'd0;
                    nxt_state  = ST_X4_EXEC;
                end
            end
            ST_X4_EXEC: begin
                if (P2_Set_CM1) begin
                    nxt_state = ST_FETCH;
                end
            end
            default: begin
                nxt_state = ST_FETCH;
            end
        endcase

        // Decoder flag clears act in every state and have the final say.
        if (P2_Reset_XIX) begin
            nxt_xix = 1'b0;
        end
        if (P2_Reset_XIY) begin
            nxt_xiy = 1'b0;
        end
    end

    // State, flags and all outputs registered from the next-state values so
    // enables and inverted buses line up with the state they describe.
    always_ff @(posedge CLK or negedge notReset) begin
        if (!notReset) begin
            state       <= ST_FETCH;
            xix         <= 1'b0;
            xiy         <= 1'b0;
            Source      <= 8'h00;
            notSource   <= 8'hFF;
            XPT         <= 5'd0;
            notXPT      <= 5'h1F;
            Disp        <= 8'h00;
            CM1         <= 1'b1;
            XIX_enable  <= 1'b0;
            Main_enable <= 1'b0;
            XIX4_enable <= 1'b0;
        end else begin
            state       <= nxt_state;
            xix         <= nxt_xix;
            xiy         <= nxt_xiy;
            Source      <= nxt_source;
            notSource   <= ~nxt_source;
            XPT         <= nxt_xpt;
            notXPT      <= ~nxt_xpt;
            Disp        <= nxt_disp;
            CM1         <= (nxt_state == ST_FETCH) || (nxt_state == ST_X4_DISP);
            XIX_enable  <= (nxt_state == ST_EXEC) && (nxt_xix || nxt_xiy);
            Main_enable <= (nxt_state == ST_EXEC) && !(nxt_xix || nxt_xiy);
            XIX4_enable <= (nxt_state == ST_X4_EXEC);
        end
    end

endmodule

// File: tb/tb_xix_prefix_sequencer.sv
// Bench for the DD/FD prefix sequencer: directed scenarios plus randomized
// strobes, checked every cycle against a behavioural instruction-level model.
module tb_xix_prefix_sequencer;

    logic       CLK = 1'b0;
    logic       notReset;
    logic [7:0] Dt_in;
    logic       fetch_valid, step, P2_Set_CM1, PR_Reset_XPT;
    logic       P2_Reset_XIX, P2_Reset_XIY, P2_Set_XIX4_0, P2_Set_XIY4_0;
    logic [7:0] Source, notSource, Disp;
    logic [4:0] XPT, notXPT;
    logic       is_Y, CM1, XIX_enable, Main_enable, XIX4_enable;

    int n_vec = 0;
    int n_err = 0;

    xix_prefix_sequencer dut (
        .CLK(CLK), .notReset(notReset), .Dt_in(Dt_in), .fetch_valid(fetch_valid),
        .step(step), .P2_Set_CM1(P2_Set_CM1), .PR_Reset_XPT(PR_Reset_XPT),
        .P2_Reset_XIX(P2_Reset_XIX), .P2_Reset_XIY(P2_Reset_XIY),
        .P2_Set_XIX4_0(P2_Set_XIX4_0), .P2_Set_XIY4_0(P2_Set_XIY4_0),
        .Source(Source), .notSource(notSource), .XPT(XPT), .notXPT(notXPT),
        .is_Y(is_Y), .Disp(Disp), .CM1(CM1), .XIX_enable(XIX_enable),
        .Main_enable(Main_enable), .XIX4_enable(XIX4_enable)
    );

    always #5 CLK = ~CLK;

    // Reference model: where the instruction is, which index register is
    // selected, and the latched bytes and phase.
    localparam int P_FETCH = 0, P_EXEC = 1, P_DISP = 2, P_OP = 3, P_CBEXEC = 4;
    int         m_phase;
    bit         m_ix, m_iy;
    logic [7:0] m_src, m_disp;
    int         m_xpt;

    task automatic model_reset();
        m_phase = P_FETCH; m_ix = 0; m_iy = 0;
        m_src = 8'h00; m_disp = 8'h00; m_xpt = 0;
    endtask

    task automatic model_clock();
        int nx;
        nx = m_xpt;
        if (PR_Reset_XPT) nx = 0;
        else if (step) nx = (m_xpt + 1 > 31) ? 31 : m_xpt + 1;
        if (m_phase == P_FETCH && fetch_valid) begin
            if (Dt_in == 8'hDD) begin m_ix = 1; m_iy = 0; end
            else if (Dt_in == 8'hFD) begin m_ix = 0; m_iy = 1; end
            else begin m_src = Dt_in; nx = 0; m_phase = P_EXEC; end
        end else if (m_phase == P_EXEC) begin
            if (P2_Set_CM1) m_phase = P_FETCH;
            else if (P2_Set_XIX4_0 || P2_Set_XIY4_0) begin
                m_phase = P_DISP; nx = 0;
                m_ix = P2_Set_XIX4_0; m_iy = !P2_Set_XIX4_0;
            end
        end else if (m_phase == P_DISP && fetch_valid) begin
            m_disp = Dt_in; m_phase = P_OP;
        end else if (m_phase == P_OP && fetch_valid) begin
            m_src = Dt_in; nx = 0; m_phase = P_CBEXEC;
        end else if (m_phase == P_CBEXEC && P2_Set_CM1) begin
            m_phase = P_FETCH;
        end
        if (P2_Reset_XIX) m_ix = 0;
        if (P2_Reset_XIY) m_iy = 0;
        m_xpt = nx;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        logic [4:0] x;
        x = m_xpt[4:0];
        chk("Source", Source, m_src);
        chk("notSource", notSource, ~m_src);
        chk("Disp", Disp, m_disp);
        chk("XPT", {3'b0, XPT}, {3'b0, x});
        chk("notXPT", {3'b0, notXPT}, {3'b0, ~x});
        chk("is_Y", {7'b0, is_Y}, {7'b0, m_iy});
        chk("CM1", {7'b0, CM1}, {7'b0, (m_phase == P_FETCH || m_phase == P_DISP)});
        chk("XIX_enable", {7'b0, XIX_enable}, {7'b0, (m_phase == P_EXEC && (m_ix || m_iy))});
        chk("Main_enable", {7'b0, Main_enable}, {7'b0, (m_phase == P_EXEC && !(m_ix || m_iy))});
        chk("XIX4_enable", {7'b0, XIX4_enable}, {7'b0, (m_phase == P_CBEXEC)});
    endtask

    task automatic idle_inputs();
        Dt_in = 8'h00; fetch_valid = 0; step = 0; P2_Set_CM1 = 0; PR_Reset_XPT = 0;
        P2_Reset_XIX = 0; P2_Reset_XIY = 0; P2_Set_XIX4_0 = 0; P2_Set_XIY4_0 = 0;
    endtask

    // One clock with the current inputs; outputs checked 1 ns after the edge,
    // then the inputs return to idle.
    task automatic cyc();
        @(posedge CLK);
        model_clock();
        #1;
        chk_model();
        idle_inputs();
    endtask

    task automatic fetch(input logic [7:0] b);
        Dt_in = b; fetch_valid = 1; cyc();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".Source"}, Source, 8'h00);
        chk({tag, ".notSource"}, notSource, 8'hFF);
        chk({tag, ".XPT"}, {3'b0, XPT}, 8'h00);
        chk({tag, ".notXPT"}, {3'b0, notXPT}, 8'h1F);
        chk({tag, ".Disp"}, Disp, 8'h00);
        chk({tag, ".CM1"}, {7'b0, CM1}, 8'h01);
        chk({tag, ".enables"}, {5'b0, XIX_enable, Main_enable, XIX4_enable}, 8'h00);
        chk({tag, ".is_Y"}, {7'b0, is_Y}, 8'h00);
    endtask

    initial begin
        idle_inputs();
        notReset = 0;
        model_reset();
        #23;
        chk_reset_values("reset");
        notReset = 1;
        @(posedge CLK); #1;

        // Unprefixed opcode.
        fetch(8'h3E);
        chk("plain.Main_enable", {7'b0, Main_enable}, 8'h01);
        chk("plain.XIX_enable", {7'b0, XIX_enable}, 8'h00);
        chk("plain.Source", Source, 8'h3E);
        chk("plain.notSource", notSource, 8'hC1);
        chk("plain.XPT", {3'b0, XPT}, 8'h00);
        chk("plain.notXPT", {3'b0, notXPT}, 8'h1F);
        P2_Set_CM1 = 1; cyc();

        // DD E1 with stepping, then combined end-of-instruction strobes.
        fetch(8'hDD);
        fetch(8'hE1);
        for (int i = 1; i <= 3; i++) begin
            step = 1; cyc();
            chk("dd.XPT", {3'b0, XPT}, 8'(i));
            chk("dd.XIX_enable", {7'b0, XIX_enable}, 8'h01);
            chk("dd.is_Y", {7'b0, is_Y}, 8'h00);
        end
        P2_Set_CM1 = 1; PR_Reset_XPT = 1; P2_Reset_XIX = 1; cyc();
        chk("end.CM1", {7'b0, CM1}, 8'h01);
        chk("end.XPT", {3'b0, XPT}, 8'h00);
        chk("end.enables", {5'b0, XIX_enable, Main_enable, XIX4_enable}, 8'h00);

        // Chained prefixes: last wins; fetch_valid in EXEC ignored.
        fetch(8'hDD);
        fetch(8'hFD);
        fetch(8'hE9);
        chk("chain.is_Y", {7'b0, is_Y}, 8'h01);
        chk("chain.XIX_enable", {7'b0, XIX_enable}, 8'h01);
        fetch(8'h77);
        chk("chain.Source", Source, 8'hE9);
        P2_Set_CM1 = 1; P2_Reset_XIY = 1; cyc();

        // Saturation of XPT in EXEC of a plain opcode.
        fetch(8'h00);
        for (int i = 0; i < 40; i++) begin step = 1; cyc(); end
        chk("sat.XPT", {3'b0, XPT}, 8'h1F);
        chk("sat.notXPT", {3'b0, notXPT}, 8'h00);
        step = 1; PR_Reset_XPT = 1; cyc();
        chk("sat.clear", {3'b0, XPT}, 8'h00);
        P2_Set_CM1 = 1; cyc();

        // FD CB d op sequence.
        fetch(8'hFD);
        fetch(8'hCB);
        P2_Set_XIY4_0 = 1; cyc();
        chk("cb.CM1_disp", {7'b0, CM1}, 8'h01);
        fetch(8'h05);
        chk("cb.CM1_op", {7'b0, CM1}, 8'h00);
        fetch(8'h46);
        chk("cb.Disp", Disp, 8'h05);
        chk("cb.Source", Source, 8'h46);
        chk("cb.XIX4_enable", {7'b0, XIX4_enable}, 8'h01);
        chk("cb.is_Y", {7'b0, is_Y}, 8'h01);
        chk("cb.XIX_enable", {7'b0, XIX_enable}, 8'h00);

        // Asynchronous reset mid X4_EXEC.
        #3;
        notReset = 0;
        #1;
        chk_reset_values("async");
        model_reset();
        #2;
        notReset = 1;
        @(posedge CLK); #1;
        fetch(8'h21);
        chk("post.Main_enable", {7'b0, Main_enable}, 8'h01);
        P2_Set_CM1 = 1; cyc();

        // Randomized strobes and bytes.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(3))
                0: Dt_in = 8'hDD;
                1: Dt_in = 8'hFD;
                2: Dt_in = 8'hCB;
                default: Dt_in = 8'($urandom);
            endcase
            fetch_valid   = ($urandom_range(1) == 1);
            step          = ($urandom_range(1) == 1);
            PR_Reset_XPT  = ($urandom_range(9) == 0);
            P2_Set_CM1    = ($urandom_range(7) == 0);
            P2_Reset_XIX  = ($urandom_range(15) == 0);
            P2_Reset_XIY  = ($urandom_range(15) == 0);
            P2_Set_XIX4_0 = ($urandom_range(5) == 0);
            P2_Set_XIY4_0 = !P2_Set_XIX4_0 && ($urandom_range(5) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
